duart_bus_arb: RTL and testbench
================================

Name: duart_bus_arb

Overview:
- Owns the register bus of the 2681-style DUART (4-bit addr, 8-bit data, clken-qualified enable/we).
- After reset it runs a fixed configuration sequence: mask interrupts, clear output port, load timer preset, stop the timer.
- It then arbitrates single register accesses between two requesters, the CPU and an auxiliary (monitor/debug) port.
- Every DUART access is delivered as exactly one clken-qualified enable pulse, because reads of 0xE/0xF have side effects (timer start/stop).

Parameters:
- INIT_DELAY, 16, number of clken cycles to wait after reset release before the first init access (0 allowed).
- CT_PRESET, 16'h0000, timer preset written to addr 0x6 (high byte) and addr 0x7 (low byte) during init.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- clken  in  1  DUART clock enable; a DUART access takes effect on a clk edge where clken=1.
- cpu_req  in  1  CPU access request; held with we/addr/di stable until cpu_ack.
- cpu_we  in  1  1=write, 0=read.
- cpu_addr  in  4  DUART register address.
- cpu_di  in  8  write data.
- cpu_do  out  8  registered read data; valid with cpu_ack and held until the next CPU read completes.
- cpu_ack  out  1  one-clk completion pulse.
- aux_req, aux_we, aux_addr[3:0], aux_di[7:0], aux_do[7:0], aux_ack: same meanings for the auxiliary requester.
- duart_enable  out  1  to DUART enable.
- duart_we  out  1  to DUART we.
- duart_addr  out  4  to DUART addr.
- duart_di  out  8  to DUART di.
- duart_do  in  8  from DUART do (combinational on addr).
- init_done  out  1  high once the init sequence completes.
- reinit  in  1  re-run init request (functional only with the optional feature).

Behaviour:
- Reset values: state=S_DELAY, delay counter=INIT_DELAY, table index=0, last_grant=AUX (so CPU wins the first tie).
- Reset values of outputs: init_done=0, cpu_ack=0, aux_ack=0, cpu_do=0x00, aux_do=0x00, duart_enable=0, duart_we=0, duart_addr=0x0, duart_di=0x00.
- Reset asserted mid-access aborts the access immediately; no ack is issued.
- Bus outputs are driven combinationally from the state and the granted requester's inputs. duart_enable=1 only in S_INIT, S_CPU and S_AUX.
- An access completes on the first clk edge in its state where clken=1. Exactly one such edge occurs per access.
- Init table, entry {we, addr, data}:
  - 0: W 0x5 0x00 (IMR cleared).
  - 1: W 0xF 0xFF (OP all bits cleared).
  - 2: W 0x6 CT_PRESET[15:8].
  - 3: W 0x7 CT_PRESET[7:0].
  - 4: R 0xF (stop timer, clear counter interrupt); read data discarded.
- State S_DELAY: decrement the delay counter on each clken; when the counter is 0 go to S_INIT. With INIT_DELAY=0, S_INIT is entered on the first clk after reset release.
- State S_INIT: drive the current table entry. On a clken edge: if index=4, set init_done=1, index=0 and go to S_IDLE; else index+1 and stay in S_INIT.
- State S_IDLE: duart_enable=0. Grant is decided from registered inputs on every clk, not only on clken:
  - only cpu_req → S_CPU;
  - only aux_req → S_AUX;
  - both → the requester that is not last_grant (round-robin);
  - on grant, update last_grant.
- State S_CPU / S_AUX: drive the granted requester's we/addr/di. On a clken edge:
  - capture duart_do into xxx_do when we=0; on writes xxx_do is unchanged;
  - pulse xxx_ack on the next clk;
  - return to S_IDLE.
- Minimum access latency, request to ack: 2 clk when clken is held high. Back-to-back accesses from one requester need 1 idle cycle.
- A requester must drop req in the cycle after its ack, otherwise the request is treated as a new access.
- Requests raised during S_DELAY/S_INIT are held, with no ack, until init_done=1.
- Changes to req inputs while their access is in progress are ignored until completion.

Optional Feature:
- Macro: DUART_ARB_REINIT_EN.
- Defined: a reinit=1 sampled in S_IDLE → init_done=0, index=0, go to S_DELAY (delay counter reloaded). An access already in S_CPU/S_AUX completes first, then the reinit is taken; the request is latched in a pending flag.
- Undefined: reinit is ignored; init runs only after reset.

Test Plan:
- Reset with INIT_DELAY=2, CT_PRESET=16'h1234, clken every 4th clk → init starts after 2 clken. Bus shows, in order: W5/00, WF/FF, W6/12, W7/34, RF, each with enable high across exactly one clken edge. init_done rises after the RF access.
- After init, CPU read addr 0x5 with duart_do=0x08, clken=1 continuous → cpu_ack 2 clk after cpu_req; cpu_do=0x08; aux_ack stays 0.
- cpu_req and aux_req raised in the same cycle, repeated for 4 accesses each → grants alternate CPU, AUX, CPU, AUX…; each requester gets exactly one ack per request.
- CPU read of addr 0xE with clken low for 10 clk after grant → duart_enable held high for 10 clk, only one clken edge observed with enable high; single cpu_ack.
- cpu_req asserted at clk 1 after reset → no ack until init_done=1; request then serviced with correct data.
- With DUART_ARB_REINIT_EN: pulse reinit during an aux write → aux_ack issued first, then init_done=0 and the full 5-entry sequence repeats. Without the macro, the same stimulus leaves init_done=1 and issues no further init accesses.

Source files
------------

// File: rtl/duart_bus_arb.sv
// duart_bus_arb: owns the 2681 DUART register bus, runs the post-reset
// init table, then round-robins single accesses between CPU and AUX.
// Ports: clk, reset_n, clken; cpu_/aux_ req,we,addr,di,do,ack;
// duart_enable/we/addr/di/do; init_done; reinit.
// Optional: DUART_ARB_REINIT_EN makes reinit re-run the init table.
module duart_bus_arb #(
  parameter int          INIT_DELAY = 16,
  parameter logic [15:0] CT_PRESET  = 16'h0000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clken,
  input  logic       cpu_req,
  input  logic       cpu_we,
  input  logic [3:0] cpu_addr,
  input  logic [7:0] cpu_di,
  output logic [7:0] cpu_do,
  output logic       cpu_ack,
  input  logic       aux_req,
  input  logic       aux_we,
  input  logic [3:0] aux_addr,
  input  logic [7:0] aux_di,
  output logic [7:0] aux_do,
  output logic       aux_ack,
  output logic       duart_enable,
  output logic       duart_we,
  output logic [3:0] duart_addr,
  output logic [7:0] duart_di,
  input  logic [7:0] duart_do,
  output logic       init_done,
  input  logic       reinit
);

  typedef enum logic [2:0] {
    S_DELAY, S_INIT, S_IDLE, S_CPU, S_AUX
  } state_t;

  localparam logic [15:0] DLY_LOAD = 16'(INIT_DELAY);

  state_t      state;
  logic [15:0] dly;
  logic [2:0]  idx;
  logic        last_aux;
  logic        cpu_want;
  logic        aux_want;
  logic        grant_cpu;
  logic        grant_aux;
  logic        reinit_go;

  // A requester still showing its ack cycle is not re-granted;
  // this is the mandatory idle cycle between its accesses.
  assign cpu_want  = cpu_req & ~cpu_ack;
  assign aux_want  = aux_req & ~aux_ack;
  assign grant_cpu = cpu_want & (~aux_want | last_aux);
  assign grant_aux = aux_want & ~grant_cpu;

`ifdef DUART_ARB_REINIT_EN
  logic pend;

  // A reinit seen mid-access waits here until the bus is idle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend <= 1'b0;
    end else if (state == S_IDLE) begin
      pend <= 1'b0;
    end else if ((state == S_CPU || state == S_AUX) && reinit) begin
      pend <= 1'b1;
    end
  end

  assign reinit_go = reinit | pend;
`else
  logic unused_reinit;
  assign unused_reinit = reinit;
  assign reinit_go     = 1'b0;
`endif

  always_comb begin
    duart_enable = 1'b0;
    duart_we     = 1'b0;
    duart_addr   = 4'h0;
    duart_di     = 8'h00;
    unique case (state)
      S_INIT: begin
        duart_enable = 1'b1;
        unique case (idx)
          3'd0: begin
            duart_we = 1'b1; duart_addr = 4'h5; duart_di = 8'h00;
          end
          3'd1: begin
            duart_we = 1'b1; duart_addr = 4'hF; duart_di = 8'hFF;
          end
          3'd2: begin
            duart_we = 1'b1; duart_addr = 4'h6;
            duart_di = CT_PRESET[15:8];
          end
          3'd3: begin
            duart_we = 1'b1; duart_addr = 4'h7;
            duart_di = CT_PRESET[7:0];
          end
          default: begin
            duart_we = 1'b0; duart_addr = 4'hF;
          end
        endcase
      end
      S_CPU: begin
        duart_enable = 1'b1;
        duart_we     = cpu_we;
        duart_addr   = cpu_addr;
        duart_di     = cpu_di;
      end
      S_AUX: begin
        duart_enable = 1'b1;
        duart_we     = aux_we;
        duart_addr   = aux_addr;
        duart_di     = aux_di;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_DELAY;
      dly       <= DLY_LOAD;
      idx       <= 3'd0;
      last_aux  <= 1'b1;
      init_done <= 1'b0;
      cpu_ack   <= 1'b0;
      aux_ack   <= 1'b0;
      cpu_do    <= 8'h00;
      aux_do    <= 8'h00;
    end else begin
      cpu_ack <= 1'b0;
      aux_ack <= 1'b0;
      unique case (state)
        S_DELAY: begin
          if (dly == 16'd0) begin
            state <= S_INIT;
          end else if (clken) begin
            dly <= dly - 16'd1;
          end
        end
        S_INIT: begin
          if (clken) begin
            if (idx == 3'd4) begin
              init_done <= 1'b1;
              idx       <= 3'd0;
              state     <= S_IDLE;
            end else begin
              idx <= idx + 3'd1;
            end
          end
        end
        S_IDLE: begin
          if (reinit_go) begin
            init_done <= 1'b0;
            idx       <= 3'd0;
            dly       <= DLY_LOAD;
            state     <= S_DELAY;
          end else if (grant_cpu) begin
            last_aux <= 1'b0;
            state    <= S_CPU;
          end else if (grant_aux) begin
            last_aux <= 1'b1;
            state    <= S_AUX;
          end
        end
        S_CPU: begin
          if (clken) begin
            if (!cpu_we) cpu_do <= duart_do;
            cpu_ack <= 1'b1;
            state   <= S_IDLE;
          end
        end
        S_AUX: begin
          if (clken) begin
            if (!aux_we) aux_do <= duart_do;
            aux_ack <= 1'b1;
            state   <= S_IDLE;
          end
        end
        default: state <= S_DELAY;
      endcase
    end
  end

endmodule

// File: tb/tb_duart_bus_arb.sv
// tb_duart_bus_arb: directed checks of init table, arbitration,
// clken stalls, held early requests and reinit.
module tb_duart_bus_arb;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       clken = 1'b0;
  logic       cpu_req = 1'b0, cpu_we = 1'b0;
  logic [3:0] cpu_addr = 4'h0;
  logic [7:0] cpu_di = 8'h00, cpu_do;
  logic       cpu_ack;
  logic       aux_req = 1'b0, aux_we = 1'b0;
  logic [3:0] aux_addr = 4'h0;
  logic [7:0] aux_di = 8'h00, aux_do;
  logic       aux_ack;
  logic       duart_enable, duart_we;
  logic [3:0] duart_addr;
  logic [7:0] duart_di, duart_do;
  logic       init_done;
  logic       reinit = 1'b0;

  int checks = 0;
  int errors = 0;

  int   ck_mode = 1;
  int   ck_cnt  = 0;
  logic [7:0] do_base = 8'h00;
  logic [12:0] ev_q[$];
  int cpu_acks = 0;
  int aux_acks = 0;

  logic [12:0] exp_init [5] = '{13'h1500, 13'h1FFF, 13'h1612,
                                13'h1734, 13'h0F00};

  duart_bus_arb #(.INIT_DELAY(2), .CT_PRESET(16'h1234)) dut (
    .clk(clk), .reset_n(reset_n), .clken(clken),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_di(cpu_di), .cpu_do(cpu_do), .cpu_ack(cpu_ack),
    .aux_req(aux_req), .aux_we(aux_we), .aux_addr(aux_addr),
    .aux_di(aux_di), .aux_do(aux_do), .aux_ack(aux_ack),
    .duart_enable(duart_enable), .duart_we(duart_we),
    .duart_addr(duart_addr), .duart_di(duart_di),
    .duart_do(duart_do), .init_done(init_done), .reinit(reinit)
  );

  always #5 clk = ~clk;

  assign duart_do = do_base ^ {4'h0, duart_addr};

  // mode 0: clken always, 1: every 4th clk, 2: held low
  always @(posedge clk) begin
    #1;
    ck_cnt = ck_cnt + 1;
    case (ck_mode)
      0:       clken = 1'b1;
      1:       clken = (ck_cnt % 4 == 0);
      default: clken = 1'b0;
    endcase
  end

  always @(negedge clk) begin
    if (reset_n && duart_enable && clken)
      ev_q.push_back({duart_we, duart_addr, duart_di});
    if (cpu_ack) cpu_acks = cpu_acks + 1;
    if (aux_ack) aux_acks = aux_acks + 1;
  end

  task automatic do_reset();
    @(posedge clk); #1;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    ev_q.delete();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({init_done, cpu_ack, aux_ack, duart_enable, duart_we}
        !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags got %b want 00000",
               {init_done, cpu_ack, aux_ack, duart_enable, duart_we});
    end
    checks++;
    if ({cpu_do, aux_do} !== 16'h0000) begin
      errors++;
      $display("FAIL reset_do got %h want 0000", {cpu_do, aux_do});
    end
    checks++;
    if ({duart_addr, duart_di} !== 12'h000) begin
      errors++;
      $display("FAIL reset_bus got %h want 000",
               {duart_addr, duart_di});
    end
  endtask

  task automatic test_init();
    int seen = 0;
    ck_mode = 1;
    reset_n = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (init_done) begin seen = 1; break; end
    end
    checks++;
    if (seen != 1) begin
      errors++;
      $display("FAIL init_timeout got 0 want 1");
    end
    checks++;
    if (ev_q.size() != 5) begin
      errors++;
      $display("FAIL init_count got %0d want 5", ev_q.size());
    end
    for (int i = 0; i < 5 && i < ev_q.size(); i++) begin
      checks++;
      if (ev_q[i][12:8] !== exp_init[i][12:8] ||
          (i < 4 && ev_q[i][7:0] !== exp_init[i][7:0])) begin
        errors++;
        $display("FAIL init_entry%0d got %h want %h",
                 i, ev_q[i], exp_init[i]);
      end
    end
  endtask

  task automatic test_early_req();
    int early = 0;
    int got = 0;
    do_reset();
    ck_mode = 1;
    do_base = 8'h20;
    reset_n = 1'b1;
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 4'h3;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (cpu_ack && !init_done) early++;
      if (cpu_ack) begin got = 1; break; end
    end
    @(posedge clk); #1;
    cpu_req = 1'b0;
    checks++;
    if (early != 0 || got != 1) begin
      errors++;
      $display("FAIL early_ack got early=%0d ack=%0d want 0 1",
               early, got);
    end
    checks++;
    if (cpu_do !== 8'h23) begin
      errors++;
      $display("FAIL early_data got %h want 23", cpu_do);
    end
    checks++;
    if (ev_q.size() != 6 || ev_q[5][12:8] !== 5'h03) begin
      errors++;
      $display("FAIL early_bus got n=%0d want 6 last 03",
               ev_q.size());
    end
  endtask

  task automatic test_cpu_read();
    int lat = 0;
    int a0;
    ck_mode = 0;
    do_base = 8'h0D;
    repeat (2) @(posedge clk);
    #1;
    a0 = aux_acks;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 4'h5;
    for (int i = 1; i < 20; i++) begin
      @(posedge clk); #1;
      if (cpu_ack) begin lat = i; break; end
    end
    cpu_req = 1'b0;
    checks++;
    if (lat != 2) begin
      errors++;
      $display("FAIL cpu_latency got %0d want 2", lat);
    end
    checks++;
    if (cpu_do !== 8'h08) begin
      errors++;
      $display("FAIL cpu_read got %h want 08", cpu_do);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (aux_acks != a0) begin
      errors++;
      $display("FAIL cpu_no_aux got %0d want %0d", aux_acks, a0);
    end
  endtask

  task automatic test_round_robin();
    int order[$];
    int c0, a0;
    int alt_bad = 0;
    do_base = 8'h40;
    c0 = cpu_acks; a0 = aux_acks;
    for (int r = 0; r < 4; r++) begin
      int cd = 0;
      int ad = 0;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 4'h2;
      aux_req = 1'b1; aux_we = 1'b0; aux_addr = 4'hB;
      for (int i = 0; i < 20; i++) begin
        @(posedge clk); #1;
        if (cpu_ack) begin order.push_back(0); cpu_req = 1'b0; cd = 1; end
        if (aux_ack) begin order.push_back(1); aux_req = 1'b0; ad = 1; end
        if (cd == 1 && ad == 1) break;
      end
      cpu_req = 1'b0; aux_req = 1'b0;
      @(posedge clk); #1;
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (order.size() != 8 || order[0] != 1) begin
      errors++;
      $display("FAIL rr_first got n=%0d want 8 aux-first",
               order.size());
    end
    for (int i = 1; i < order.size(); i++)
      if (order[i] == order[i-1]) alt_bad++;
    checks++;
    if (alt_bad != 0) begin
      errors++;
      $display("FAIL rr_alternate got %0d repeats want 0", alt_bad);
    end
    checks++;
    if (cpu_acks - c0 != 4 || aux_acks - a0 != 4) begin
      errors++;
      $display("FAIL rr_acks got %0d/%0d want 4/4",
               cpu_acks - c0, aux_acks - a0);
    end
    checks++;
    if (cpu_do !== 8'h42 || aux_do !== 8'h4B) begin
      errors++;
      $display("FAIL rr_data got %h/%h want 42/4B", cpu_do, aux_do);
    end
  endtask

  task automatic test_clken_stall();
    int lo = 0;
    int hi = 0;
    int acks = 0;
    ck_mode = 2;
    do_base = 8'h90;
    repeat (2) @(posedge clk);
    #1;
    ev_q.delete();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 4'hE;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (duart_enable && !clken) lo++;
      if (duart_enable && clken) hi++;
      if (lo == 10) ck_mode = 0;
      if (cpu_ack) begin acks++; cpu_req = 1'b0; end
    end
    checks++;
    if (lo != 10) begin
      errors++;
      $display("FAIL stall_hold got %0d want 10", lo);
    end
    checks++;
    if (hi != 1 || acks != 1) begin
      errors++;
      $display("FAIL stall_single got edges=%0d acks=%0d want 1 1",
               hi, acks);
    end
    checks++;
    if (cpu_do !== 8'h9E || ev_q.size() != 1) begin
      errors++;
      $display("FAIL stall_data got %h n=%0d want 9E 1",
               cpu_do, ev_q.size());
    end
  endtask

  task automatic test_reinit();
    int seen;
    ck_mode = 0;
    do_base = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    ev_q.delete();
    aux_req = 1'b1; aux_we = 1'b1; aux_addr = 4'h9; aux_di = 8'h77;
    @(posedge clk); #1;
    reinit = 1'b1;
    @(posedge clk); #1;
    reinit = 1'b0;
    checks++;
    if (aux_ack !== 1'b1 || init_done !== 1'b1) begin
      errors++;
      $display("FAIL reinit_ack_first got ack=%b done=%b want 1 1",
               aux_ack, init_done);
    end
    aux_req = 1'b0;
    checks++;
    if (aux_do !== 8'h4B) begin
      errors++;
      $display("FAIL reinit_wr_do got %h want 4B", aux_do);
    end
`ifdef DUART_ARB_REINIT_EN
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!init_done) begin seen = 1; break; end
    end
    checks++;
    if (seen != 1) begin
      errors++;
      $display("FAIL reinit_drop got 0 want 1");
    end
    seen = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (init_done) begin seen = 1; break; end
    end
    checks++;
    if (seen != 1 || ev_q.size() != 6) begin
      errors++;
      $display("FAIL reinit_rerun got done=%0d n=%0d want 1 6",
               seen, ev_q.size());
    end
    for (int i = 0; i < 5 && i + 1 < ev_q.size(); i++) begin
      checks++;
      if (ev_q[i+1][12:8] !== exp_init[i][12:8] ||
          (i < 4 && ev_q[i+1][7:0] !== exp_init[i][7:0])) begin
        errors++;
        $display("FAIL reinit_entry%0d got %h want %h",
                 i, ev_q[i+1], exp_init[i]);
      end
    end
`else
    seen = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!init_done) seen++;
    end
    checks++;
    if (seen != 0 || ev_q.size() != 1) begin
      errors++;
      $display("FAIL reinit_ignored got low=%0d n=%0d want 0 1",
               seen, ev_q.size());
    end
`endif
    checks++;
    if (ev_q.size() < 1 || ev_q[0] !== 13'h1977) begin
      errors++;
      $display("FAIL reinit_aux_bus got %h want 1977",
               ev_q.size() > 0 ? ev_q[0] : 13'h0);
    end
  endtask

  initial begin
    test_reset();
    test_init();
    test_early_req();
    test_cpu_read();
    test_round_robin();
    test_clken_stall();
    test_reinit();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
